// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int CNT_W          = 8 * HDR_BYTES;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM  = 3'd5,
`endif
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_e;

    function automatic logic is_ready(input state_e s);
        logic r;
        r = (s == HDR0) || (s == HDR1) || (s == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        r = r || (s == CSUM);
`endif
        return r;
    endfunction

    function automatic logic is_busy(input state_e s);
        return !((s == IDLE) || (s == DONE) || (s == ERR));
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Collects bytes little-endian into a word; full_o flags the push that completes it.
// word_o is the word including the byte being pushed this cycle.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [7:0]        byte_i,
    output logic              full_o,
    output logic [WORD_W-1:0] word_o
);

    logic [LANE_W-1:0] lane_q;
    logic [WORD_W-1:0] sr_q;

    assign word_o = {byte_i, sr_q[WORD_W-1:8]};
    assign full_o = push_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            sr_q   <= '0;
        end else if (clear_i) begin
            lane_q <= '0;
            sr_q   <= '0;
        end else if (push_i) begin
            lane_q <= lane_q + LANE_W'(1);
            sr_q   <= word_o;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into a word-wide instruction memory.
// Optional trailing XOR checksum is built in when IMEM_LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for load_start_i
// HDR0  | take word count low byte
// HDR1  | take word count high byte, range check
// DATA  | pack payload bytes into a word
// WRITE | one-cycle memory write strobe
// CSUM  | compare trailing checksum byte (checksum build only)
// DONE  | load completed, held until next start
// ERR   | load aborted, held until next start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           load_start_i,
    input  logic [7:0]                     rx_data_i,
    input  logic                           rx_valid_i,
    output logic                           rx_ready_o,
    output logic                           we_o,
    output logic [$clog2(MEM_DEPTH)+1:2]   waddr_o,
    output logic [31:0]                    wdata_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int AW = $clog2(MEM_DEPTH);

    state_e            state_q, state_d;
    logic              rx_ready_q, we_q, busy_q, done_q, err_q;
    logic [AW-1:0]     waddr_q;
    logic [31:0]       wdata_q;
    logic [AW-1:0]     idx_q;
    logic [CNT_W-1:0]  remain_q;
    logic [7:0]        hdr_lo_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic              accept, start, push;
    logic              pk_full;
    logic [31:0]       pk_word;
    logic [CNT_W-1:0]  n_hdr;
    logic              n_bad, last_word;

    assign accept    = rx_valid_i && rx_ready_q;
    assign start     = load_start_i && !is_busy(state_q);
    assign push      = accept && (state_q == DATA);
    assign n_hdr     = {rx_data_i, hdr_lo_q};
    assign n_bad     = (n_hdr == '0) || (32'(n_hdr) > MEM_DEPTH);
    // remain_q counts words still to be written; terminal count is the final word
    assign last_word = (remain_q == CNT_W'(1));

    imem_byte_packer u_packer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (start),
        .push_i  (push),
        .byte_i  (rx_data_i),
        .full_o  (pk_full),
        .word_o  (pk_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (load_start_i) state_d = HDR0;
            HDR0:            if (accept) state_d = HDR1;
            HDR1:            if (accept) state_d = n_bad ? ERR : DATA;
            DATA:            if (pk_full) state_d = WRITE;
            WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:            if (accept) state_d = (rx_data_i == csum_q) ? DONE : ERR;
`endif
            default:         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            idx_q      <= '0;
            remain_q   <= '0;
            hdr_lo_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rx_ready_q <= is_ready(state_d);
            we_q       <= (state_d == WRITE);
            busy_q     <= is_busy(state_d);
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == ERR);

            if (start) begin
                idx_q    <= '0;
                remain_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_q   <= '0;
`endif
            end

            case (state_q)
                HDR0: if (accept) hdr_lo_q <= rx_data_i;
                HDR1: if (accept) remain_q <= n_hdr;
                DATA: begin
                    if (pk_full) begin
                        waddr_q <= idx_q;
                        wdata_q <= pk_word;
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept) csum_q <= csum_q ^ rx_data_i;
`endif
                end
                WRITE: begin
                    idx_q    <= idx_q + AW'(1);
                    remain_q <= remain_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign rx_ready_o = rx_ready_q;
    assign we_o       = we_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued per load and a
// monitor pops them whenever we_o is seen. Covers IMEM_LOADER_CHECKSUM_EN builds too.
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n, load_start, rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready_o, we_o, busy_o, done_o, err_o;
    logic [AW+1:2] waddr_o;
    logic [31:0]   wdata_o;

    always #5 clk = ~clk;

    imem_loader #(.MEM_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_start_i (load_start),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready_o),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    int         errors = 0;
    int         checks = 0;
    wr_t        exp_q[$];
    logic [7:0] pl[$];
    logic       prev_we;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cs_delta;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    initial begin
        prev_we = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (we_o) begin
                chk("we_single_cycle", 32'(prev_we), 32'd0);
                chk("ready_low_in_write", 32'(rx_ready_o), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %08h expected no write", waddr_o, wdata_o);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("waddr", 32'(waddr_o), 32'(e.addr));
                    chk("wdata", wdata_o, e.data);
                end
            end
            prev_we = we_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int gap_for(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, input bit exp_we);
        bit acc;
        bit got;
        got = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 60 && !got; t++) begin
            acc = rx_ready_o;
            @(posedge clk);
            if (acc) got = 1'b1;
            else @(negedge clk);
        end
        #1;
        rx_valid = 1'b0;
        chk("byte_accepted", 32'(got), 32'd1);
        if (got && exp_we) chk("we_latency", 32'(we_o), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic fill_random(input int nwords);
        pl.delete();
        for (int i = 0; i < 4 * nwords; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference: word w = bytes 4w..4w+3 little-endian, written at address w.
    task automatic run_load(input logic [7:0] h0, input logic [7:0] h1, input int mode, input int mid_start);
        int         n;
        bit         ok;
        bit         exp_err;
        logic [7:0] x;
        int         t;
        n  = int'({h1, h0});
        ok = (n != 0) && (n <= DEPTH);
        x  = 8'h00;
        if (ok) begin
            for (int w = 0; w < n; w++) begin
                wr_t e;
                e.addr = w;
                e.data = 32'(pl[4*w]) + (32'(pl[4*w+1]) << 8) + (32'(pl[4*w+2]) << 16) + (32'(pl[4*w+3]) << 24);
                exp_q.push_back(e);
                for (int k = 0; k < 4; k++) x = x ^ pl[4*w+k];
            end
        end
        pulse_start();
        send_byte(h0, gap_for(mode), 1'b0);
        send_byte(h1, gap_for(mode), 1'b0);
        if (!ok) begin
            chk("hdr_err", 32'(err_o), 32'd1);
            chk("hdr_ready", 32'(rx_ready_o), 32'd0);
            chk("hdr_busy", 32'(busy_o), 32'd0);
            chk("hdr_done", 32'(done_o), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            chk("hdr_err_held", 32'(err_o), 32'd1);
            return;
        end
        for (int i = 0; i < 4 * n; i++) begin
            if (i == mid_start) pulse_start();
            send_byte(pl[i], gap_for(mode), (i % 4) == 3);
        end
        exp_err = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x ^ cs_delta, gap_for(mode), 1'b0);
        exp_err = (cs_delta != 8'h00);
`endif
        t = 0;
        while (!(done_o || err_o) && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("end_done", 32'(done_o), 32'(!exp_err));
        chk("end_err", 32'(err_o), 32'(exp_err));
        chk("end_busy", 32'(busy_o), 32'd0);
        chk("end_ready", 32'(rx_ready_o), 32'd0);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero();
        chk("rst_ready", 32'(rx_ready_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_waddr", 32'(waddr_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
        cs_delta   = 8'h00;
`endif
        repeat (3) @(negedge clk);
        chk_outputs_zero();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_ready", 32'(rx_ready_o), 32'd0);

        // Directed image, continuous then every-other-cycle valid
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load(8'h02, 8'h00, 0, -1);
        run_load(8'h02, 8'h00, 1, -1);

        // Bad headers: zero words and 257 words
        run_load(8'h00, 8'h00, 0, -1);
        run_load(8'h01, 8'h01, 0, -1);

        // Start request mid-payload is ignored
        fill_random(4);
        run_load(8'h04, 8'h00, 2, 5);
        fill_random(2);
        run_load(8'h02, 8'h00, 0, 4);

        // Largest legal image fills the whole memory
        fill_random(DEPTH);
        run_load(8'(DEPTH % 256), 8'(DEPTH / 256), 0, -1);

        // Reset after six payload bytes: only word 0 is written
        begin
            wr_t e;
            fill_random(3);
            e.addr = 0;
            e.data = {pl[3], pl[2], pl[1], pl[0]};
            exp_q.push_back(e);
            pulse_start();
            send_byte(8'h03, 0, 1'b0);
            send_byte(8'h00, 0, 1'b0);
            for (int i = 0; i < 6; i++) send_byte(pl[i], 0, (i % 4) == 3);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk_outputs_zero();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk("post_rst_busy", 32'(busy_o), 32'd0);
            chk("post_rst_ready", 32'(rx_ready_o), 32'd0);
            chk("post_rst_writes", 32'(exp_q.size()), 32'd0);
            fill_random(2);
            run_load(8'h02, 8'h00, 0, -1);
        end

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 8));
            fill_random(n);
            run_load(8'(n), 8'h00, 2, -1);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Payload XOR is 04: checksum 05 aborts after the write, 04 completes
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        cs_delta = 8'h01;
        run_load(8'h01, 8'h00, 0, -1);
        cs_delta = 8'h00;
        run_load(8'h01, 8'h00, 0, -1);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 256, is the target memory depth in 32-bit words and SHALL be a power of two ≥ 4.
REQ-002 clk_i  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 load_start_i  input  1  single-cycle request to begin a load.
REQ-005 rx_data_i  input  8  incoming byte.
REQ-006 rx_valid_i  input  1  rx_data_i is valid.
REQ-007 rx_ready_o  output  1  loader accepts a byte this cycle.
REQ-008 we_o  output  1  memory write strobe, single-cycle pulse.
REQ-009 waddr_o  output  [$clog2(MEM_DEPTH)-1+2:2]  word-aligned write address.
REQ-010 wdata_o  output  32  write data.
REQ-011 busy_o  output  1  load in progress.
REQ-012 done_o  output  1  last load completed without error.
REQ-013 err_o  output  1  last load aborted.

Function
REQ-014 A byte SHALL be accepted only on a cycle where rx_valid_i && rx_ready_o.
REQ-015 The FSM SHALL have the states IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE and ERR.
REQ-016 IDLE, DONE and ERR SHALL go to HDR0 on load_start_i; load_start_i SHALL be ignored in every other state.
REQ-017 HDR0 and HDR1 SHALL capture a 16-bit little-endian word count N (low byte first), then go to DATA.
REQ-018 After HDR1 the FSM SHALL go to ERR instead of DATA if N == 0 or N > MEM_DEPTH.
REQ-019 DATA SHALL pack 4 accepted bytes little-endian (first byte into wdata[7:0]), then go to WRITE.
REQ-020 WRITE SHALL last exactly one cycle, with we_o=1, waddr_o=current index and wdata_o=the packed word.
REQ-021 The word index SHALL start at 0 per load and increment after each WRITE.
REQ-022 After the N-th WRITE the FSM SHALL go to CSUM if enabled (REQ-029), else to DONE; otherwise it SHALL return to DATA.
REQ-023 rx_ready_o SHALL be 1 only in HDR0, HDR1, DATA and CSUM.
REQ-024 busy_o SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-025 done_o SHALL be 1 only in DONE, and err_o SHALL be 1 only in ERR; both SHALL be held until the next load_start_i.
REQ-026 we_o SHALL never assert outside WRITE; waddr_o and wdata_o SHALL hold their last value otherwise.
REQ-027 Latency from acceptance of the 4th byte of a word to we_o SHALL be exactly 1 cycle.

Reset
REQ-028 While rst_ni=0 the block SHALL be in IDLE with all outputs 0, the index, count and checksum cleared, and a partial load discarded without any write; the first edge after release SHALL be an IDLE cycle.

Configuration
REQ-029 With IMEM_LOADER_CHECKSUM_EN defined, the block SHALL maintain a running XOR of all payload bytes (header excluded).
REQ-030 In that build, CSUM SHALL accept one byte and go to DONE if it equals the XOR, else to ERR.
REQ-031 Words already written before a checksum mismatch SHALL remain written.
REQ-032 Without IMEM_LOADER_CHECKSUM_EN, the CSUM state and the XOR register SHALL be absent and the FSM SHALL go from the final WRITE directly to DONE.

Structure
REQ-033 Package imem_loader_pkg SHALL hold the FSM state enum, HDR_BYTES=2 and BYTES_PER_WORD=4.
REQ-034 One sub-module, imem_byte_packer, SHALL own the 2-bit byte lane counter and the 32-bit shift/pack register, with ports clear, push, byte and full.
REQ-035 The FSM, word index, count compare and checksum SHALL reside in imem_loader.

Verification
REQ-036 N=2, bytes 02 00 11 22 33 44 55 66 77 88 (+ checksum 00 if enabled) -> two we_o pulses: addr 0 data 0x44332211, addr 1 data 0x88776655; then done_o=1, busy_o=0.
REQ-037 rx_valid_i toggling every other cycle during the same load -> identical writes and no byte lost or duplicated.
REQ-038 Header 00 00, and header 01 01 with MEM_DEPTH=256 -> err_o=1 after HDR1, no we_o, rx_ready_o=0.
REQ-039 rst_ni low after 6 payload bytes -> exactly one write (addr 0), outputs 0 during reset; a following load_start_i runs a clean load from addr 0.
REQ-040 load_start_i pulsed mid-load -> ignored; load completes normally.
REQ-041 Checksum build, N=1, payload 01 02 03 04, checksum 05 -> err_o=1 with addr 0 already written; checksum 04 -> done_o=1.
